// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: round-robin sharing of one external 8-bit LFSR, streaming seeded bursts to requesters
module lfsr_arbiter #(
  parameter int NREQ = 4,
  parameter int LEN_W = 8,
  parameter logic [7:0] RESET_SEED = 8'h01,
  parameter logic [7:0] ZERO_SUB = 8'h01,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*8-1:0]     req_seed,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  lfsr_load,
  output logic [7:0]            lfsr_seed,
  input  logic [7:0]            lfsr_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [IW-1:0]         out_id,
  output logic                  out_last
);
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, rr, pick, j;
  logic [7:0] seed_l, sel_seed;
  logic [LEN_W-1:0] len_l, cnt, sel_len;
  logic [NREQ-1:0] onehot;
  logic found, xfer;
  always_comb begin
    found = 1'b0;
    pick = '0;
    j = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = IW'((int'(rr) + i) % NREQ);
      if (!found && req[j]) begin
        found = 1'b1;
        pick = j;
      end
    end
    sel_seed = req_seed[8*int'(pick) +: 8];
    sel_len = req_len[LEN_W*int'(pick) +: LEN_W];
  end
  always_comb begin
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    busy = state != IDLE;
    gnt = busy ? onehot : '0;
    done = (rst && state == DONE) ? onehot : '0;
    out_valid = rst && state == STREAM;
    out_data = lfsr_q;
    out_id = idx;
    out_last = out_valid && cnt == len_l - 1'b1;
    xfer = out_valid && out_ready;
    lfsr_load = !rst || state == LOAD;
    lfsr_seed = !rst ? RESET_SEED : (state == LOAD && seed_l == 8'h00) ? ZERO_SUB : seed_l;
    state_n = state;
    unique case (state)
      IDLE:    state_n = !found ? IDLE : (sel_len != '0) ? LOAD : DONE;
      LOAD:    state_n = STREAM;
      STREAM:  state_n = (xfer && out_last) ? DONE : STREAM;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clock) begin
    if (!rst) begin
      idx <= '0;
      rr <= '0;
      seed_l <= '0;
      len_l <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && found) begin
        idx <= pick;
        seed_l <= sel_seed;
        len_l <= sel_len;
        cnt <= '0;
      end
      if (xfer) cnt <= cnt + 1'b1;
      if (state == DONE) rr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end
endmodule
